// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour HH:MM clock with a three-state set FSM.
// The clock has three modes: RUN keeps time, SET_HRS sets the hours and
// SET_MIN sets the minutes. The digit being set blinks by blanking it on
// alternate blink phases. The time digits, blank mask, sec_tick and mode
// are all flop outputs.
//
// Button handshake: btn_mode and btn_inc are one-cycle, clock-synchronous
// pulses that are consumed on the rising edge where they are high. There is
// no back-pressure, so each pulse acts exactly once. If both buttons are
// high in the same cycle, btn_mode wins and btn_inc is dropped.
module clock_time_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] hrs_tens,
  output logic [3:0] blank,
  output logic       sec_tick,
  output logic [1:0] mode
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // The encoding doubles as the mode output, so mode is the state register.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    sec, sec_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          phase, phase_nxt;
  logic [3:0]    mo_nxt, mt_nxt, ho_nxt, ht_nxt;
  logic          tick_nxt;
  logic [3:0]    blank_nxt;

  // Adds one minute in BCD. The result is {wrap, tens, ones}, and wrap is
  // set when 59 rolls over to 00.
  function automatic logic [8:0] min_inc(input logic [3:0] t, input logic [3:0] o);
    logic [3:0] nt, no;
    logic       w;
    w  = 1'b0;
    nt = t;
    if (o >= 4'd9) begin
      no = 4'd0;
      if (t >= 4'd5) begin
        nt = 4'd0;
        w  = 1'b1;
      end else begin
        nt = t + 4'd1;
      end
    end else begin
      no = o + 4'd1;
    end
    return {w, nt, no};
  endfunction

  // Adds one hour in BCD and wraps 23 back to 00.
  function automatic logic [7:0] hrs_inc(input logic [3:0] t, input logic [3:0] o);
    logic [3:0] nt, no;
    if (t >= 4'd2 && o >= 4'd3) begin
      nt = 4'd0;
      no = 4'd0;
    end else if (o >= 4'd9) begin
      nt = t + 4'd1;
      no = 4'd0;
    end else begin
      nt = t;
      no = o + 4'd1;
    end
    return {nt, no};
  endfunction

  assign mode = state;

  // Computes the next state, time and blink values. blank and sec_tick are
  // derived from these next values so that they change on the same edge as
  // the state they describe.
  always_comb begin
    logic [8:0] m;
    logic [7:0] h;
    state_nxt = state;
    presc_nxt = presc;
    sec_nxt   = sec;
    blink_nxt = blink_cnt;
    phase_nxt = phase;
    mo_nxt    = min_ones;
    mt_nxt    = min_tens;
    ho_nxt    = hrs_ones;
    ht_nxt    = hrs_tens;
    tick_nxt  = 1'b0;
    m         = min_inc(min_tens, min_ones);
    h         = hrs_inc(hrs_tens, hrs_ones);

    if (btn_mode) begin
      // Every state entry restarts timekeeping and blinking from zero.
      case (state)
        RUN:     state_nxt = SET_HRS;
        SET_HRS: state_nxt = SET_MIN;
        default: state_nxt = RUN;
      endcase
      presc_nxt = '0;
      sec_nxt   = '0;
      blink_nxt = '0;
      phase_nxt = 1'b0;
    end else begin
      case (state)
        RUN: begin
          blink_nxt = '0;
          phase_nxt = 1'b0;
          if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            if (sec >= 6'd59) begin
              sec_nxt = '0;
              mo_nxt  = m[3:0];
              mt_nxt  = m[7:4];
              if (m[8]) begin
                ho_nxt = h[3:0];
                ht_nxt = h[7:4];
              end
            end else begin
              sec_nxt = sec + 6'd1;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        SET_HRS, SET_MIN: begin
          presc_nxt = '0;
          sec_nxt   = '0;
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase;
          end else begin
            blink_nxt = blink_cnt + BW'(1);
          end
          if (btn_inc && state == SET_HRS) begin
            ho_nxt = h[3:0];
            ht_nxt = h[7:4];
          end
          if (btn_inc && state == SET_MIN) begin
            mo_nxt = m[3:0];
            mt_nxt = m[7:4];
          end
        end
        default: begin
          state_nxt = RUN;
          presc_nxt = '0;
          sec_nxt   = '0;
          blink_nxt = '0;
          phase_nxt = 1'b0;
        end
      endcase
    end

    case (state_nxt)
      SET_HRS: blank_nxt = {phase_nxt, phase_nxt, 2'b00};
      SET_MIN: blank_nxt = {2'b00, phase_nxt, phase_nxt};
      default: blank_nxt = 4'b0000;
    endcase
  end

  // Holds the FSM state, the counters and every output register. The reset
  // is asynchronous, so it clears everything at once without a clock edge.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      presc     <= '0;
      sec       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      min_ones  <= 4'd0;
      min_tens  <= 4'd0;
      hrs_ones  <= 4'd0;
      hrs_tens  <= 4'd0;
      blank     <= 4'b0000;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      sec       <= sec_nxt;
      blink_cnt <= blink_nxt;
      phase     <= phase_nxt;
      min_ones  <= mo_nxt;
      min_tens  <= mt_nxt;
      hrs_ones  <= ho_nxt;
      hrs_tens  <= ht_nxt;
      blank     <= blank_nxt;
      sec_tick  <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl with TICK_DIV=4 and BLINK_DIV=3.
// Table-driven button vectors, plus directed sequences for rollover,
// blinking and asynchronous reset.
module tb_clock_time_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_mode   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic [3:0] min_ones, min_tens, hrs_ones, hrs_tens, blank;
  logic       sec_tick;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        m;
    logic        i;
    logic [15:0] t;
    logic [1:0]  md;
    logic [3:0]  bl;
  } vec_t;

  vec_t vecs[11];

  clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .hrs_ones   (hrs_ones),
    .hrs_tens   (hrs_tens),
    .blank      (blank),
    .sec_tick   (sec_tick),
    .mode       (mode)
  );

  // clock / reset
  always #5 clk_100MHz = ~clk_100MHz;

  function automatic logic [15:0] now_time();
    return {hrs_tens, hrs_ones, min_tens, min_ones};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given buttons. Outputs are stable 1 ns after the edge.
  task automatic cycle(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk_100MHz);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b1);
  endtask

  // Runs n idle cycles and checks that sec_tick is high on every 4th one.
  task automatic run_check_ticks(input string name, input int n);
    for (int k = 1; k <= n; k++) begin
      cycle(1'b0, 1'b0);
      check(name, {15'd0, sec_tick}, {15'd0, (k % 4 == 0)});
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0001, 2'd0, 4'b0000}; // inc ignored in RUN
    vecs[1]  = '{1'b1, 1'b0, 16'h0001, 2'd1, 4'b0000}; // enter SET_HRS
    vecs[2]  = '{1'b0, 1'b1, 16'h0101, 2'd1, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0201, 2'd1, 4'b0000};
    vecs[4]  = '{1'b0, 1'b0, 16'h0201, 2'd1, 4'b1100}; // blink phase 1
    vecs[5]  = '{1'b0, 1'b1, 16'h0301, 2'd1, 4'b1100};
    vecs[6]  = '{1'b1, 1'b1, 16'h0301, 2'd2, 4'b0000}; // mode wins over inc
    vecs[7]  = '{1'b0, 1'b1, 16'h0302, 2'd2, 4'b0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h0303, 2'd2, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 16'h0304, 2'd2, 4'b0011};
    vecs[10] = '{1'b1, 1'b0, 16'h0304, 2'd0, 4'b0000}; // back to RUN

    // reset state
    #2;
    check("reset_time", now_time(), 16'h0000);
    check("reset_mode", {14'd0, mode}, 16'd0);
    check("reset_blank", {12'd0, blank}, 16'd0);
    check("reset_tick", {15'd0, sec_tick}, 16'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;

    // one minute of RUN
    for (int k = 1; k <= 240; k++) begin
      cycle(1'b0, 1'b0);
      check("run_tick", {15'd0, sec_tick}, {15'd0, (k % 4 == 0)});
      if (k == 239) check("run_pre_min", now_time(), 16'h0000);
    end
    check("run_one_min", now_time(), 16'h0001);
    check("run_mode", {14'd0, mode}, 16'd0);

    // table-driven vectors
    for (int v = 0; v < 11; v++) begin
      cycle(vecs[v].m, vecs[v].i);
      check($sformatf("vec%0d_time", v), now_time(), vecs[v].t);
      check($sformatf("vec%0d_mode", v), {14'd0, mode}, {14'd0, vecs[v].md});
      check($sformatf("vec%0d_blank", v), {12'd0, blank}, {12'd0, vecs[v].bl});
      check($sformatf("vec%0d_tick", v), {15'd0, sec_tick}, 16'd0);
    end

    // blink phases in SET_HRS, then a restart in SET_MIN
    cycle(1'b1, 1'b0);
    check("blink_hrs_0", {12'd0, blank}, 16'h0);
    for (int k = 1; k < 9; k++) begin
      cycle(1'b0, 1'b0);
      check($sformatf("blink_hrs_%0d", k), {12'd0, blank},
            (k >= 3 && k <= 5) ? 16'h000c : 16'h0000);
      check("blink_hrs_tick", {15'd0, sec_tick}, 16'd0);
    end
    cycle(1'b1, 1'b0);
    check("blink_min_0", {12'd0, blank}, 16'h0);
    for (int k = 1; k < 6; k++) begin
      cycle(1'b0, 1'b0);
      check($sformatf("blink_min_%0d", k), {12'd0, blank},
            (k >= 3) ? 16'h0003 : 16'h0000);
    end

    // minute wrap in SET_MIN does not carry into hours
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    press_inc(9);
    check("set_hrs_12", now_time(), 16'h1204);
    cycle(1'b1, 1'b0);
    press_inc(55);
    check("set_min_59", now_time(), 16'h1259);
    press_inc(1);
    check("min_wrap_no_carry", now_time(), 16'h1200);
    cycle(1'b1, 1'b0);
    check("back_run_mode", {14'd0, mode}, 16'd0);

    // hour wrap in SET_HRS, then 23:59 rollover in RUN
    cycle(1'b1, 1'b0);
    press_inc(11);
    check("set_hrs_23", now_time(), 16'h2300);
    press_inc(1);
    check("hrs_wrap", now_time(), 16'h0000);
    press_inc(23);
    cycle(1'b1, 1'b0);
    press_inc(59);
    check("set_2359", now_time(), 16'h2359);
    cycle(1'b1, 1'b0);
    check("run_2359_mode", {14'd0, mode}, 16'd0);
    check("run_2359_blank", {12'd0, blank}, 16'd0);
    run_check_ticks("roll_tick", 239);
    check("roll_pre", now_time(), 16'h2359);
    cycle(1'b0, 1'b0);
    check("roll_tick_240", {15'd0, sec_tick}, 16'd1);
    check("roll_midnight", now_time(), 16'h0000);
    check("roll_hrs", {8'd0, hrs_tens, hrs_ones}, 16'h0000);

    // mode and inc together in SET_HRS at 05:30
    cycle(1'b1, 1'b0);
    press_inc(5);
    cycle(1'b1, 1'b0);
    press_inc(30);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("pre_both_0530", now_time(), 16'h0530);
    cycle(1'b1, 1'b1);
    check("both_mode", {14'd0, mode}, 16'd2);
    check("both_time", now_time(), 16'h0530);

    // asynchronous reset in SET_MIN at 07:45
    press_inc(15);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    press_inc(2);
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
    check("pre_rst_time", now_time(), 16'h0745);
    check("pre_rst_blank", {12'd0, blank}, 16'h0003);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_time", now_time(), 16'h0000);
    check("async_rst_mode", {14'd0, mode}, 16'd0);
    check("async_rst_blank", {12'd0, blank}, 16'd0);
    check("async_rst_tick", {15'd0, sec_tick}, 16'd0);

    // first tick after release comes on the 4th edge
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    run_check_ticks("post_rst_tick", 8);
    check("post_rst_time", now_time(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
